// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream into 32-bit instruction RAM writes.
// Optional trailing-checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK = 3'd4;
`endif
    localparam logic [2:0] ST_DONE  = 3'd5;

    // A length byte of zero, or anything beyond the RAM size, means a full RAM image.
    localparam logic [ADDR_W:0] FULL_N = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   idx_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       word_r;
    logic              in_ready_r;
    logic              we_r;
    logic [ADDR_W-1:0] wa_r;
    logic [31:0]       wd_r;
    logic              busy_r;
    logic              done_r;
    logic              cpu_rst_n_r;
    logic              xfer_s;
    logic              last_word_s;
    logic [ADDR_W:0]   len_s;
    logic [ADDR_W+8:0] data_ext_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
    logic              err_r;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign xfer_s      = in_valid & in_ready_r;
    assign last_word_s = ((idx_r + {{ADDR_W{1'b0}}, 1'b1}) == len_r);

    // Decode the length byte into a word count, clamped to the RAM size.
    always_comb begin
        data_ext_s = {{(ADDR_W + 1){1'b0}}, in_data};
        if ((in_data == 8'h00) || (data_ext_s > {8'h00, FULL_N})) begin
            len_s = FULL_N;
        end else begin
            len_s = data_ext_s[ADDR_W:0];
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_s = ST_LEN;
                else       state_s = state_r;
            end
            ST_LEN: begin
                if (xfer_s) state_s = ST_DATA;
                else        state_s = state_r;
            end
            ST_DATA: begin
                if (xfer_s && (byte_cnt_r == 2'd3)) state_s = ST_WRITE;
                else                                state_s = state_r;
            end
            ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_word_s) state_s = ST_CHECK;
`else
                if (last_word_s) state_s = ST_DONE;
`endif
                else             state_s = ST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer_s) state_s = ST_DONE;
                else        state_s = state_r;
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Control state and registered status/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            we_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cpu_rst_n_r <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_r       <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready_r <= (state_s == ST_LEN) || (state_s == ST_DATA) || (state_s == ST_CHECK);
`else
            in_ready_r <= (state_s == ST_LEN) || (state_s == ST_DATA);
`endif
            we_r       <= (state_s == ST_WRITE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        cpu_rst_n_r <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        err_r       <= 1'b0;
`endif
                    end
                end
                ST_WRITE: begin
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (last_word_s) begin
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        cpu_rst_n_r <= 1'b1;
                    end
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer_s) begin
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        err_r       <= (in_data != csum_r);
                        cpu_rst_n_r <= (in_data == csum_r);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Datapath: length, word assembly, write address/data and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r      <= {(ADDR_W + 1){1'b0}};
            idx_r      <= {(ADDR_W + 1){1'b0}};
            byte_cnt_r <= 2'd0;
            word_r     <= 24'h000000;
            wa_r       <= {ADDR_W{1'b0}};
            wd_r       <= 32'h00000000;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_r      <= {(ADDR_W + 1){1'b0}};
                        byte_cnt_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= 8'h00;
`endif
                    end
                end
                ST_LEN: begin
                    if (xfer_s) begin
                        len_r      <= len_s;
                        idx_r      <= {(ADDR_W + 1){1'b0}};
                        byte_cnt_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= csum_update(csum_r, in_data);
`endif
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= csum_update(csum_r, in_data);
`endif
                        case (byte_cnt_r)
                            2'd0:    word_r[7:0]   <= in_data;
                            2'd1:    word_r[15:8]  <= in_data;
                            2'd2:    word_r[23:16] <= in_data;
                            default: begin
                                wd_r <= {in_data, word_r};
                                wa_r <= BASE_ADDR + idx_r[ADDR_W-1:0];
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    idx_r <= idx_r + {{ADDR_W{1'b0}}, 1'b1};
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign we        = we_r;
    assign wa        = wa_r;
    assign wd        = wd_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cpu_rst_n = cpu_rst_n_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err       = err_r;
`else
    assign err       = 1'b0;
`endif

endmodule
